// File: rtl/or_reg.sv
// Registered bitwise-OR leaf with ready/valid handshake, sticky accumulation and reduction flags.
// Optional popcount output y_count is enabled by defining OR_POPCOUNT_EN.
module or_reg #(
  parameter int REG_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_WIDTH-1:0] a,
  input  logic [REG_WIDTH-1:0] b,
  input  logic                 acc_en,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_WIDTH-1:0] y,
  output logic                 y_any,
  output logic                 y_all,
  output logic                 y_zero
`ifdef OR_POPCOUNT_EN
  ,
  output logic [$clog2(REG_WIDTH+1)-1:0] y_count
`endif
);

  localparam int CNT_W = $clog2(REG_WIDTH + 1);

  logic [REG_WIDTH-1:0] y_p0;
  logic [REG_WIDTH-1:0] y_p1;
  logic                 vld_p1;
  logic                 accept_p0;

  // Stage p0: handshake and next-result selection
  assign in_ready  = !vld_p1 || out_ready;
  assign accept_p0 = in_valid && in_ready;
  assign y_p0      = acc_en ? (y_p1 | a | b) : (a | b);

`ifdef OR_POPCOUNT_EN
  function automatic logic [CNT_W-1:0] popcount(input logic [REG_WIDTH-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < REG_WIDTH; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  logic [CNT_W-1:0] cnt_p1;
`endif

  // Stage p1: held result; y is kept after consumption so accumulation can continue
  always_ff @(posedge clk) begin
    if (rst || acc_clr) begin
      y_p1   <= '0;
      vld_p1 <= 1'b0;
`ifdef OR_POPCOUNT_EN
      cnt_p1 <= '0;
`endif
    end else if (accept_p0) begin
      y_p1   <= y_p0;
      vld_p1 <= 1'b1;
`ifdef OR_POPCOUNT_EN
      cnt_p1 <= popcount(y_p0);
`endif
    end else if (vld_p1 && out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign y         = y_p1;
  assign out_valid = vld_p1;
  assign y_any     = |y_p1;
  assign y_all     = &y_p1;
  assign y_zero    = (y_p1 == '0);

`ifdef OR_POPCOUNT_EN
  assign y_count = cnt_p1;
`endif

endmodule

// File: tb/tb_or_reg.sv
// Directed scoreboard bench for or_reg: expected results are queued as stimulus is accepted
// and checked against the registered outputs on every falling edge.
module tb_or_reg;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         acc_en;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         y_any;
  logic         y_all;
  logic         y_zero;
`ifdef OR_POPCOUNT_EN
  logic [$clog2(W+1)-1:0] y_count;
`endif

  or_reg #(.REG_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_any     (y_any),
    .y_all     (y_all),
    .y_zero    (y_zero)
`ifdef OR_POPCOUNT_EN
    ,
    .y_count   (y_count)
`endif
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] q[$];
  logic         m_vld;
  logic [W-1:0] m_y;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the current state before the edge, then advance the expectation queue.
  task automatic tick(input logic [W-1:0] exp_y);
    logic [W-1:0] cur;
    logic         acc;
    @(negedge clk);
    cur = (m_vld && q.size() > 0) ? q[0] : m_y;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_vld || out_ready)});
    chk("y", {29'd0, y}, {29'd0, cur});
    chk("y_any", {31'd0, y_any}, {31'd0, (cur != '0)});
    chk("y_all", {31'd0, y_all}, {31'd0, (cur == '1)});
    chk("y_zero", {31'd0, y_zero}, {31'd0, (cur == '0)});
`ifdef OR_POPCOUNT_EN
    chk("y_count", 32'(y_count), 32'($countones(cur)));
`endif
    acc = in_valid && (!m_vld || out_ready);
    if (rst || acc_clr) begin
      q.delete();
      m_vld = 1'b0;
      m_y   = '0;
    end else begin
      if (m_vld && out_ready) begin
        void'(q.pop_front());
        m_vld = 1'b0;
      end
      if (acc) begin
        q.push_back(exp_y);
        m_y   = exp_y;
        m_vld = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ten,
                      input logic [W-1:0] exp_y);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    acc_en   = ten;
    tick(exp_y);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    acc_en   = 1'b0;
    a        = '0;
    b        = '0;
    tick('0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    acc_en    = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    m_vld     = 1'b0;
    m_y       = '0;
    @(posedge clk);
    #1;
    tick('0);
    rst = 1'b0;

    // Plain OR, one per cycle
    send(3'b000, 3'b000, 1'b0, 3'b000);
    send(3'b000, 3'b001, 1'b0, 3'b001);
    send(3'b001, 3'b000, 1'b0, 3'b001);
    send(3'b001, 3'b001, 1'b0, 3'b001);
    send(3'b101, 3'b010, 1'b0, 3'b111);
    send(3'b100, 3'b000, 1'b0, 3'b100);
    idle();
    idle();

    // Sticky accumulation, including after the result was consumed
    acc_clr = 1'b1;
    idle();
    acc_clr = 1'b0;
    send(3'b001, 3'b000, 1'b1, 3'b001);
    send(3'b000, 3'b010, 1'b1, 3'b011);
    send(3'b100, 3'b000, 1'b1, 3'b111);
    idle();
    send(3'b000, 3'b000, 1'b1, 3'b111);
    idle();
    acc_clr = 1'b1;
    idle();
    acc_clr = 1'b0;
    idle();
    // Clear discards a same-cycle accept
    acc_clr = 1'b1;
    send(3'b110, 3'b001, 1'b0, 3'b111);
    acc_clr = 1'b0;
    idle();

    // Backpressure then same-cycle consume and accept
    send(3'b001, 3'b010, 1'b0, 3'b011);
    out_ready = 1'b0;
    send(3'b100, 3'b000, 1'b0, 3'b100);
    send(3'b100, 3'b000, 1'b0, 3'b100);
    out_ready = 1'b1;
    send(3'b100, 3'b000, 1'b0, 3'b100);
    idle();
    idle();

    // Synchronous reset mid-stream with a pending accumulate
    send(3'b101, 3'b000, 1'b0, 3'b101);
    rst = 1'b1;
    send(3'b010, 3'b000, 1'b1, 3'b111);
    rst = 1'b0;
    idle();
    send(3'b010, 3'b000, 1'b1, 3'b010);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/or_reg.md
Name: or_reg

Overview:
- Registered, parameterizable bitwise-OR unit: y = a | b, captured on a ready/valid handshake, with optional sticky accumulation and reduction flags.
- Used as a small datapath leaf wherever a flag/mask merge with one cycle of latency and backpressure is needed.

Parameters:
- REG_WIDTH, 3, bit width of a, b and y (legal: >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  a/b/acc_en present this cycle.
- in_ready  output  1  unit can accept input this cycle.
- a  input  REG_WIDTH  operand A.
- b  input  REG_WIDTH  operand B.
- acc_en  input  1  sticky mode: OR the operands into the held result instead of replacing it.
- acc_clr  input  1  clear the held result and flags (no handshake needed).
- out_valid  output  1  y and flags hold a valid result.
- out_ready  input  1  consumer accepts the result.
- y  output  REG_WIDTH  registered result.
- y_any  output  1  reduction OR of y.
- y_all  output  1  reduction AND of y.
- y_zero  output  1  y == 0.

Behaviour:
- Reset (rst=1 at posedge): y=0, out_valid=0, y_any=0, y_all=0, y_zero=1. Reset overrides every other input.
- in_ready = !out_valid || out_ready. Combinational; no path from in_valid to in_ready.
- Accept = in_valid && in_ready. On accept, at the next posedge:
  - acc_en=0: y <= a | b.
  - acc_en=1: y <= y | a | b. The held y is used even if out_valid=0; this is sticky accumulation since the last reset/clear.
  - out_valid <= 1.
- Latency: exactly 1 cycle from accept to out_valid=1 with the new y.
- Output handshake: the result is consumed when out_valid && out_ready. If it is consumed with no accept in the same cycle, out_valid <= 0. y keeps its value for accumulation.
- Simultaneous consume and accept: the new result is loaded and out_valid stays 1. Full throughput is one result per cycle.
- Backpressure: while out_valid=1 and out_ready=0, y, flags and out_valid are frozen and in_ready=0.
- acc_clr=1 (no reset): y <= 0, out_valid <= 0, and any accept in that cycle is discarded. Priority: rst > acc_clr > accept.
- Flags y_any, y_all and y_zero are combinational functions of registered y. They are therefore glitch-free and aligned with y.
- No X propagation: a/b are ignored unless accepted.
- Width: all operations are bitwise at REG_WIDTH with no extension. For REG_WIDTH=1, y_any=y_all=y.

Optional Feature:
- Macro OR_POPCOUNT_EN.
- Defined: adds output y_count, width $clog2(REG_WIDTH+1), equal to the number of ones in registered y. It is registered alongside y so it is valid in the same cycle. On reset or acc_clr it is 0.
- Not defined: y_count is absent from the port list. No popcount logic exists.

Test Plan:
- REG_WIDTH=3, out_ready=1, acc_en=0. Send (a,b) = (0,0), (0,1), (1,0), (1,1), one per cycle -> y = 0, 1, 1, 1 one cycle after each accept; y_zero = 1, 0, 0, 0; y_any = 0, 1, 1, 1.
- a=3'b101, b=3'b010 -> y=3'b111, y_all=1. Then a=3'b100, b=0 -> y=3'b100, y_all=0.
- Accumulate: clear, then send acc_en=1 with (3'b001,0), (0,3'b010), (3'b100,0) -> y = 001, 011, 111. Then acc_clr -> y=0, out_valid=0.
- Backpressure: hold out_ready=0 after one result -> in_ready=0; a second in_valid is not accepted and y is unchanged. Raise out_ready with in_valid=1 -> same-cycle consume+accept, out_valid stays 1, new y appears next cycle.
- Synchronous reset mid-stream: assert rst with in_valid=1 and acc_en=1 -> y=0, out_valid=0, y_zero=1 after the edge. The input is not captured and reset has no effect until a clock edge.
- With OR_POPCOUNT_EN: y=3'b101 -> y_count=2; y=3'b111 -> y_count=3; reset -> 0.
